// File: rtl/lif_neuron_ctrl.sv
// lif_neuron_ctrl: sequencing FSM for one LIF neuron (leak, integrate, check, fire, refractory)
module lif_neuron_ctrl #(
    parameter int WIDTH         = 12,
    parameter int REFRAC_CYCLES = 4,
    parameter int REFRAC_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] v_mem,
    input  logic [WIDTH-1:0] v_thresh,
    output logic [1:0]       mux_sel,
    output logic             v_en,
    output logic             spike,
    output logic             refractory,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, LEAK, INTEG, CHECK, FIRE, REFRAC, CLR} state_t;
    state_t              state_q, state_d;
    logic [REFRAC_W-1:0] cnt_q, cnt_d;
    // state and refractory counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // next state; clear overrides every other transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LEAK;
            LEAK:    state_d = INTEG;
            INTEG:   state_d = CHECK;
            CHECK:   state_d = ($signed(v_mem) >= $signed(v_thresh)) ? FIRE : IDLE;
            FIRE: begin
                cnt_d   = REFRAC_W'(REFRAC_CYCLES);
                state_d = (REFRAC_CYCLES == 0) ? IDLE : REFRAC;
            end
            REFRAC: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == REFRAC_W'(1)) state_d = IDLE;
            end
            CLR: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) state_d = CLR;
    end
    // outputs decoded from the state register only
    always_comb begin
        mux_sel    = (state_q == INTEG) ? 2'b01 : (state_q == FIRE || state_q == CLR) ? 2'b10 : 2'b00;
        v_en       = (state_q == LEAK) || (state_q == INTEG) || (state_q == FIRE) || (state_q == CLR);
        spike      = (state_q == FIRE);
        refractory = (state_q == REFRAC);
        busy       = (state_q != IDLE);
        in_ready   = (state_q == IDLE);
    end
endmodule

// File: tb/tb_lif_neuron_ctrl.sv
// tb_lif_neuron_ctrl: randomized check of two controllers (refractory 4 and 0) against a timeline model
module tb_lif_neuron_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic signed [11:0] v_mem = '0;
    logic signed [11:0] v_thresh = '0;
    logic [1:0]       rdy, en, spk, refr, bsy;
    logic [1:0][1:0]  sel;
    int n_chk = 0;
    int n_fail = 0;
    int pos[2];
    bit clr[2];
    int rc[2] = '{4, 0};
    int n_spk = 0;
    int n_rst = 0;

    always #5 clk = ~clk;

    lif_neuron_ctrl #(.WIDTH(12), .REFRAC_CYCLES(4), .REFRAC_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
        .v_mem(v_mem), .v_thresh(v_thresh), .mux_sel(sel[0]), .v_en(en[0]),
        .spike(spk[0]), .refractory(refr[0]), .busy(bsy[0])
    );
    lif_neuron_ctrl #(.WIDTH(12), .REFRAC_CYCLES(0), .REFRAC_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
        .v_mem(v_mem), .v_thresh(v_thresh), .mux_sel(sel[1]), .v_en(en[1]),
        .spike(spk[1]), .refractory(refr[1]), .busy(bsy[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // pos counts cycles since acceptance: 1 leak, 2 integrate, 3 check, 4 fire, 5.. refractory
    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int p;
            bit c;
            p = pos[i];
            c = clr[i];
            check($sformatf("mux_sel%0d", i), int'(sel[i]),
                  c ? 2 : (p == 2) ? 1 : (p == 4) ? 2 : 0);
            check($sformatf("v_en%0d", i), int'(en[i]), int'(c || p == 1 || p == 2 || p == 4));
            check($sformatf("spike%0d", i), int'(spk[i]), int'(!c && p == 4));
            check($sformatf("refractory%0d", i), int'(refr[i]), int'(!c && p >= 5));
            check($sformatf("busy%0d", i), int'(bsy[i]), int'(c || p != 0));
            check($sformatf("in_ready%0d", i), int'(rdy[i]), int'(!c && p == 0));
        end
    endtask

    task automatic step_model();
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                clr[i] = 1'b1;
                pos[i] = 0;
            end else if (clr[i]) begin
                clr[i] = 1'b0;
                pos[i] = 0;
            end else if (pos[i] == 0) pos[i] = in_valid ? 1 : 0;
            else if (pos[i] == 3) pos[i] = (v_mem >= v_thresh) ? 4 : 0;
            else if (pos[i] == 4 + rc[i]) pos[i] = 0;
            else pos[i]++;
            if (pos[i] == 4) n_spk++;
        end
    endtask

    initial begin
        int th;
        pos = '{0, 0};
        clr = '{0, 0};
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_all();
            if ((pos[0] == 7 && !clr[0] && n_rst < 3) || $urandom_range(0, 299) == 0) begin
                n_rst++;
                #2 rst_n = 1'b0;
                #1;
                pos = '{0, 0};
                clr = '{0, 0};
                check_all();
                @(negedge clk);
                check_all();
                rst_n = 1'b1;
            end
            clear    = ($urandom_range(0, 11) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            th       = int'($urandom_range(0, 400)) - 200;
            v_thresh = 12'(th);
            v_mem    = 12'(th + int'($urandom_range(0, 6)) - 3);
            @(posedge clk);
            step_model();
        end
        check("spikes_seen", int'(n_spk > 20), 1);
        check("resets_seen", int'(n_rst >= 3), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
